fetch_buffer: RTL

- Consumer-side partner of the PC register: reads the current PC, issues instruction-memory requests, and buffers returned instructions in order for the IF/ID stage.
- Decouples variable-latency instruction memory from the pipeline. Advances the PC only when a request is accepted, via pc_write_o, which feeds the PC register's write-enable.
- Discards wrong-path fetches on flush_i (branch taken / redirect).

---
 rtl/fetch_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues instruction-memory requests on credit, tags them with their PC,
// and queues returned instructions in order for IF/ID, dropping wrong-path responses after a flush.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_write_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i,
    input  logic            flush_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;

    logic [XLEN-1:0] tag_mem  [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [CW-1:0] in_flight;
    logic          slot_free;
    logic          accept;
    logic          resp;
    logic          keep;
    logic          pop;

    always_comb begin
        in_flight  = count_q + outst_q;
        slot_free  = in_flight < CW'(DEPTH);
        imem_req_o = start_i & ~flush_i & slot_free & ~rst_i;
        accept     = imem_req_o & imem_gnt_i;
        // A response with nothing outstanding is stale (e.g. straddling a reset) and is ignored.
        resp       = imem_rvalid_i & (outst_q != '0);
        keep       = resp & (drop_q == '0) & ~flush_i;
        pop        = (count_q != '0) & inst_ready_i & ~flush_i;

        count_d  = count_q + CW'(keep) - CW'(pop);
        outst_d  = outst_q + CW'(accept) - CW'(resp);
        drop_d   = drop_q - CW'(resp & (drop_q != '0));
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(keep);
        tag_wr_d = tag_wr_q + AW'(accept);
        tag_rd_d = tag_rd_q + AW'(resp);

        if (flush_i) begin
            // Everything still in flight after this edge belongs to the wrong path.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            drop_d   = outst_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= pc_i;
        end
        if (keep) begin
            data_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
        end
    end

    assign pc_write_o   = accept;
    assign imem_addr_o  = pc_i;
    assign inst_valid_o = (count_q != '0);
    // Head is masked to zero when empty so stale storage never leaks out.
    assign inst_o       = inst_valid_o ? data_mem[rd_ptr_q] : '0;
    assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr_q]   : '0;
endmodule
